// File: rtl/fft4_seq_ctrl.sv
// Sequencing controller for a 4-point FFT datapath: loads four samples,
// steps two butterfly stages, then unloads four bins with backpressure.
module fft4_seq_ctrl #(
  parameter int STAGE_LAT = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ld_en,
  output logic [1:0]       ld_idx,
  output logic             s1_en,
  output logic             s2_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_idx,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {LOAD, STG1, STG2, UNLOAD} state_t;

  // Dwell counts 0..STAGE_LAT-1, so two bits cover the legal range.
  localparam logic [1:0] DWELL_MAX = 2'(STAGE_LAT - 1);

  state_t           state, state_nxt;
  logic [1:0]       lc, lc_nxt;
  logic [1:0]       uc, uc_nxt;
  logic [1:0]       dwell, dwell_nxt;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      lc    <= '0;
      uc    <= '0;
      dwell <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      lc    <= lc_nxt;
      uc    <= uc_nxt;
      dwell <= dwell_nxt;
      if (frame_done) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    lc_nxt     = lc;
    uc_nxt     = uc;
    dwell_nxt  = dwell;
    in_ready   = 1'b0;
    ld_en      = 1'b0;
    s1_en      = 1'b0;
    s2_en      = 1'b0;
    out_valid  = 1'b0;
    frame_done = 1'b0;
    case (state)
      LOAD: begin
        in_ready = ~abort;
        // Held low during reset so only in_ready shows a non-zero reset value.
        ld_en    = in_valid & in_ready & ~rst;
        if (ld_en) begin
          lc_nxt = lc + 2'd1;
          if (lc == 2'd3) state_nxt = STG1;
        end
      end
      STG1: begin
        s1_en = (dwell == 2'd0) & ~abort;
        if (dwell == DWELL_MAX) begin
          dwell_nxt = '0;
          state_nxt = STG2;
        end else begin
          dwell_nxt = dwell + 2'd1;
        end
      end
      STG2: begin
        s2_en = (dwell == 2'd0) & ~abort;
        if (dwell == DWELL_MAX) begin
          dwell_nxt = '0;
          state_nxt = UNLOAD;
        end else begin
          dwell_nxt = dwell + 2'd1;
        end
      end
      UNLOAD: begin
        out_valid = ~abort;
        if (out_valid & out_ready) begin
          uc_nxt = uc + 2'd1;
          if (uc == 2'd3) begin
            frame_done = 1'b1;
            state_nxt  = LOAD;
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
    if (abort) begin
      state_nxt = LOAD;
      lc_nxt    = '0;
      uc_nxt    = '0;
      dwell_nxt = '0;
    end
  end

  assign ld_idx    = lc;
  assign out_idx   = uc;
  assign busy      = (state != LOAD) | (lc != 2'd0);
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_fft4_seq_ctrl.sv
// Directed bench for fft4_seq_ctrl: a STAGE_LAT=1/CNT_W=2 instance (a_*) and
// a STAGE_LAT=3 instance (b_*) share one set of inputs.
module tb_fft4_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;

  logic       a_in_ready, a_ld_en, a_s1, a_s2, a_ov, a_busy, a_fd;
  logic [1:0] a_ld_idx, a_out_idx, a_fc;
  logic       b_in_ready, b_ld_en, b_s1, b_s2, b_ov, b_busy, b_fd;
  logic [1:0] b_ld_idx, b_out_idx;
  logic [15:0] b_fc;

  fft4_seq_ctrl #(.STAGE_LAT(1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(a_in_ready),
    .ld_en(a_ld_en), .ld_idx(a_ld_idx), .s1_en(a_s1), .s2_en(a_s2), .out_valid(a_ov),
    .out_ready(out_ready), .out_idx(a_out_idx), .busy(a_busy), .frame_done(a_fd),
    .frame_cnt(a_fc));

  fft4_seq_ctrl #(.STAGE_LAT(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(b_in_ready),
    .ld_en(b_ld_en), .ld_idx(b_ld_idx), .s1_en(b_s1), .s2_en(b_s2), .out_valid(b_ov),
    .out_ready(out_ready), .out_idx(b_out_idx), .busy(b_busy), .frame_done(b_fd),
    .frame_cnt(b_fc));

  always #5 clk = ~clk;

  typedef struct packed {
    logic iv, ordy, ab;
    logic ir, ld; logic [1:0] li;
    logic s1, s2, ov; logic [1:0] oi;
    logic fd, bsy; logic [1:0] fc;
  } vec_t;

  int nchk = 0, nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic cyc(input logic iv, input logic ordy, input logic ab);
    in_valid = iv; out_ready = ordy; abort = ab;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    nxt();
    rst = 1'b0;
  endtask

  task automatic run_frame;
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (a_fd) got = 1'b1;
      nxt();
    end
    chk("frame_done_seen", 32'(got), 32'd1);
  endtask

  vec_t vt [11];

  initial begin
    // fields: iv ordy ab | ir ld li | s1 s2 ov oi | fd bsy fc
    vt[0]  = 16'b1_1_0_1_1_00_0_0_0_00_0_0_00;
    vt[1]  = 16'b1_1_0_1_1_01_0_0_0_00_0_1_00;
    vt[2]  = 16'b1_1_0_1_1_10_0_0_0_00_0_1_00;
    vt[3]  = 16'b1_1_0_1_1_11_0_0_0_00_0_1_00;
    vt[4]  = 16'b1_1_0_0_0_00_1_0_0_00_0_1_00;
    vt[5]  = 16'b1_1_0_0_0_00_0_1_0_00_0_1_00;
    vt[6]  = 16'b1_1_0_0_0_00_0_0_1_00_0_1_00;
    vt[7]  = 16'b1_1_0_0_0_00_0_0_1_01_0_1_00;
    vt[8]  = 16'b1_1_0_0_0_00_0_0_1_10_0_1_00;
    vt[9]  = 16'b1_1_0_0_0_00_0_0_1_11_1_1_00;
    vt[10] = 16'b0_1_0_1_0_00_0_0_0_00_0_0_01;

    // Reset values, with in_valid high to show ld_en stays low in reset.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_outs_a", {a_in_ready, a_ld_en, a_s1, a_s2, a_ov, a_fd, a_busy}, 7'b1000000);
    chk("rst_outs_b", {b_in_ready, b_ld_en, b_s1, b_s2, b_ov, b_fd, b_busy}, 7'b1000000);
    chk("rst_fcnt", {a_fc, b_fc}, 18'd0);
    chk("rst_idx", {a_ld_idx, a_out_idx}, 4'd0);

    // Nominal frame, STAGE_LAT=1.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cyc(vt[i].iv, vt[i].ordy, vt[i].ab);
      chk($sformatf("vec%0d_outs", i),
          {a_in_ready, a_ld_en, a_s1, a_s2, a_ov, a_fd, a_busy, a_fc},
          {vt[i].ir, vt[i].ld, vt[i].s1, vt[i].s2, vt[i].ov, vt[i].fd, vt[i].bsy, vt[i].fc});
      if (vt[i].ir) chk($sformatf("vec%0d_ld_idx", i), a_ld_idx, vt[i].li);
      if (vt[i].ov) chk($sformatf("vec%0d_out_idx", i), a_out_idx, vt[i].oi);
      nxt();
    end

    // Toggling in_valid, then a 5-cycle stall at out_idx=2.
    do_reset();
    begin
      int elc;
      elc = 0;
      for (int k = 0; k < 7; k++) begin
        cyc(k % 2 == 0, 1'b1, 1'b0);
        chk("tog_ld_en", a_ld_en, k % 2 == 0);
        chk("tog_ld_idx", a_ld_idx, elc);
        if (k % 2 == 0) elc++;
        nxt();
      end
    end
    cyc(1'b0, 1'b1, 1'b0); chk("tog_s1", a_s1, 1); nxt();
    cyc(1'b0, 1'b1, 1'b0); chk("tog_s2", a_s2, 1); nxt();
    cyc(1'b0, 1'b1, 1'b0); chk("tog_oi0", {a_ov, a_out_idx}, 3'b100); nxt();
    cyc(1'b0, 1'b1, 1'b0); chk("tog_oi1", {a_ov, a_out_idx}, 3'b101); nxt();
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk("stall_hold", {a_ov, a_out_idx, a_fd}, 4'b1100);
      nxt();
    end
    cyc(1'b0, 1'b1, 1'b0); chk("stall_oi2", {a_ov, a_out_idx, a_fd}, 4'b1100); nxt();
    cyc(1'b0, 1'b1, 1'b0); chk("stall_oi3", {a_ov, a_out_idx, a_fd}, 4'b1111); nxt();
    cyc(1'b0, 1'b0, 1'b0); chk("stall_after", {a_in_ready, a_busy, a_fc}, 4'b1001); nxt();

    // Abort in STG2, then abort at out_idx=1.
    do_reset();
    for (int k = 0; k < 4; k++) begin cyc(1'b1, 1'b1, 1'b0); nxt(); end
    cyc(1'b0, 1'b1, 1'b0); chk("ab_s1", a_s1, 1); nxt();
    cyc(1'b0, 1'b1, 1'b1); chk("ab_stg2_gate", {a_s2, a_ov, a_in_ready, a_ld_en}, 4'b0000); nxt();
    cyc(1'b0, 1'b1, 1'b0); chk("ab_stg2_after", {a_busy, a_in_ready, a_ld_idx, a_s2}, 5'b01000); nxt();
    cyc(1'b0, 1'b1, 1'b0); chk("ab_stg2_quiet", {a_s2, a_ov}, 2'b00); nxt();
    for (int k = 0; k < 4; k++) begin cyc(1'b1, 1'b1, 1'b0); nxt(); end
    cyc(1'b0, 1'b1, 1'b0); nxt();
    cyc(1'b0, 1'b1, 1'b0); nxt();
    cyc(1'b0, 1'b1, 1'b0); chk("ab_un_oi0", {a_ov, a_out_idx}, 3'b100); nxt();
    cyc(1'b0, 1'b1, 1'b1); chk("ab_un_gate", {a_ov, a_fd}, 2'b00); nxt();
    cyc(1'b0, 1'b1, 1'b0); chk("ab_un_after", {a_busy, a_ov, a_ld_idx, a_fc}, 6'b000000); nxt();

    // STAGE_LAT=3 latency and one-cycle enables.
    do_reset();
    for (int k = 0; k < 4; k++) begin cyc(1'b1, 1'b1, 1'b0); nxt(); end
    for (int k = 1; k <= 7; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk($sformatf("lat3_t%0d", k), {b_s1, b_s2, b_ov}, {k == 1, k == 4, k == 7});
      nxt();
    end

    // Asynchronous reset after two samples loaded.
    do_reset();
    for (int k = 0; k < 2; k++) begin cyc(1'b1, 1'b1, 1'b0); nxt(); end
    #2 rst = 1'b1;
    #1 chk("arst_outs", {a_in_ready, a_ld_en, a_busy, a_ld_idx, a_s1, a_ov}, 7'b1000000);
    @(posedge clk); #1 rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b0); chk("arst_ld0", {a_ld_en, a_ld_idx}, 3'b100); nxt();
    cyc(1'b1, 1'b1, 1'b0); chk("arst_ld1", {a_ld_en, a_ld_idx}, 3'b101); nxt();

    // Five frames on a 2-bit counter.
    do_reset();
    begin
      logic [1:0] exp_fc [5];
      exp_fc = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int f = 0; f < 5; f++) begin
        run_frame();
        @(negedge clk);
        chk($sformatf("fcnt_f%0d", f), a_fc, exp_fc[f]);
        nxt();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
